// File: rtl/secuenciador_arranque.sv
// secuenciador_arranque: power-up stage sequencer.
// On the first rising edge of ini it releases N_ETAPAS enables, one every
// ESPERA cycles, as a cumulative thermometer code, then raises listo.
// Optional feature macro: SECUENCIADOR_ARRANQUE_ABORT_EN. When it is defined,
// ini going low while a sequence is running or complete aborts back to idle.
module secuenciador_arranque #(
    parameter int N_ETAPAS = 4,
    parameter int ESPERA   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ini,
    output logic [N_ETAPAS-1:0] en,
    output logic                listo,
    output logic                ocupado
);

    localparam int CNT_W = ($clog2(ESPERA + 1) < 1) ? 1 : $clog2(ESPERA + 1);
    localparam int K_W   = ($clog2(N_ETAPAS + 1) < 1) ? 1 : $clog2(N_ETAPAS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ESPERA - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(N_ETAPAS - 1);

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] CONTANDO = 2'd1;
    localparam logic [1:0] LISTO    = 2'd2;

    logic [1:0]          state;
    logic                ini_prev;
    logic [CNT_W-1:0]    cnt;
    logic [K_W-1:0]      k;
    logic                arranque;
    logic                abortar;
    logic [N_ETAPAS-1:0] stage_bit;

    assign arranque = ini & ~ini_prev;
    assign ocupado  = (state == CONTANDO);

`ifdef SECUENCIADOR_ARRANQUE_ABORT_EN
    assign abortar = ~ini;
`else
    assign abortar = 1'b0;
`endif

    // One-hot mask of the stage that the current index k would release
    always_comb begin
        stage_bit = '0;
        for (int i = 0; i < N_ETAPAS; i++) begin
            if (k == K_W'(i)) begin
                stage_bit[i] = 1'b1;
            end
        end
    end

    // Previous ini level for rising-edge detection; cleared by reset so a high ini re-triggers
    always_ff @(posedge clk) begin
        if (rst) begin
            ini_prev <= 1'b0;
        end else begin
            ini_prev <= ini;
        end
    end

    // Sequencer state, gap counter, stage index and the cumulative enables
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REPOSO;
            cnt   <= '0;
            k     <= '0;
            en    <= '0;
            listo <= 1'b0;
        end else begin
            case (state)
                REPOSO: begin
                    if (arranque) begin
                        state <= CONTANDO;
                        cnt   <= '0;
                        k     <= '0;
                    end
                end
                CONTANDO: begin
                    if (abortar) begin
                        state <= REPOSO;
                        cnt   <= '0;
                        k     <= '0;
                        en    <= '0;
                        listo <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        en  <= en | stage_bit;
                        cnt <= '0;
                        if (k == K_LAST) begin
                            state <= LISTO;
                            listo <= 1'b1;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LISTO: begin
                    if (abortar) begin
                        state <= REPOSO;
                        cnt   <= '0;
                        k     <= '0;
                        en    <= '0;
                        listo <= 1'b0;
                    end
                end
                default: begin
                    state <= REPOSO;
                    cnt   <= '0;
                    k     <= '0;
                    en    <= '0;
                    listo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_arranque.sv
// Testbench for secuenciador_arranque: directed plan steps plus random ini/rst
// traffic, checked against a timeline model (releases = cycles since start / ESPERA).
// Two instances share stimulus: N_ETAPAS=3/ESPERA=4 and N_ETAPAS=4/ESPERA=1.
module tb_secuenciador_arranque;

    localparam int N0 = 3;
    localparam int W0 = 4;
    localparam int N1 = 4;
    localparam int W1 = 1;

`ifdef SECUENCIADOR_ARRANQUE_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ini = 1'b0;
    logic [N0-1:0] en0;
    logic          listo0;
    logic          ocupado0;
    logic [N1-1:0] en1;
    logic          listo1;
    logic          ocupado1;

    int checks   = 0;
    int failures = 0;

    bit m_started [2];
    bit m_prev    [2];
    int m_t       [2];
    int m_n       [2] = '{N0, N1};
    int m_w       [2] = '{W0, W1};

    secuenciador_arranque #(.N_ETAPAS(N0), .ESPERA(W0)) dut0 (
        .clk(clk), .rst(rst), .ini(ini),
        .en(en0), .listo(listo0), .ocupado(ocupado0)
    );

    secuenciador_arranque #(.N_ETAPAS(N1), .ESPERA(W1)) dut1 (
        .clk(clk), .rst(rst), .ini(ini),
        .en(en1), .listo(listo1), .ocupado(ocupado1)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference timeline by one rising edge with the given inputs
    task automatic modelEdge(input bit r, input bit i_v);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                m_started[m] = 1'b0;
                m_prev[m]    = 1'b0;
                m_t[m]       = 0;
            end else begin
                bit rise;
                rise      = i_v && !m_prev[m];
                m_prev[m] = i_v;
                if (m_started[m] && !i_v && ABORT_ON) begin
                    m_started[m] = 1'b0;
                    m_t[m]       = 0;
                end else if (!m_started[m]) begin
                    if (rise) begin
                        m_started[m] = 1'b1;
                        m_t[m]       = 0;
                    end
                end else if (m_t[m] < m_n[m] * m_w[m]) begin
                    m_t[m]++;
                end
            end
        end
    endtask

    function automatic int released(input int m);
        int r;
        r = m_started[m] ? (m_t[m] / m_w[m]) : 0;
        if (r > m_n[m]) r = m_n[m];
        return r;
    endfunction

    task automatic checkOutput();
        int r0;
        int r1;
        r0 = released(0);
        r1 = released(1);
        checkOne("en0",      {13'b0, en0},      16'((1 << r0) - 1));
        checkOne("listo0",   {15'b0, listo0},   {15'b0, (m_started[0] && r0 == N0)});
        checkOne("ocupado0", {15'b0, ocupado0}, {15'b0, (m_started[0] && r0 < N0)});
        checkOne("en1",      {12'b0, en1},      16'((1 << r1) - 1));
        checkOne("listo1",   {15'b0, listo1},   {15'b0, (m_started[1] && r1 == N1)});
        checkOne("ocupado1", {15'b0, ocupado1}, {15'b0, (m_started[1] && r1 < N1)});
    endtask

    // Drive inputs away from the edge, clock once, then compare after the falling edge
    task automatic applyStimulus(input bit r, input bit i_v);
        rst = r;
        ini = i_v;
        @(posedge clk);
        modelEdge(r, i_v);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        bit r_rand;
        bit i_rand;

        // Reset and idle with ini low
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
        checkOne("idle_en0", {13'b0, en0}, 16'h0);

        // Normal start: E is the first edge with ini high
        applyStimulus(1'b0, 1'b1);
        checkOne("ocupado_at_E", {15'b0, ocupado0}, 16'h1);
        for (int i = 1; i <= 62; i++) begin
            applyStimulus(1'b0, 1'b1);
            case (i)
                1: checkOne("fast_e1", {12'b0, en1}, 16'h1);
                2: checkOne("fast_e2", {12'b0, en1}, 16'h3);
                3: checkOne("fast_e3", {12'b0, en1}, 16'h7);
                4: begin
                    checkOne("fast_e4", {12'b0, en1}, 16'hF);
                    checkOne("fast_listo", {15'b0, listo1}, 16'h1);
                    checkOne("plan_e4", {13'b0, en0}, 16'h1);
                end
                8: checkOne("plan_e8", {13'b0, en0}, 16'h3);
                12: begin
                    checkOne("plan_e12", {13'b0, en0}, 16'h7);
                    checkOne("plan_listo", {15'b0, listo0}, 16'h1);
                    checkOne("plan_ocupado", {15'b0, ocupado0}, 16'h0);
                end
                default: ;
            endcase
        end
        checkOne("stable_en0", {13'b0, en0}, 16'h7);

        // ini held high through reset starts on the first post-reset clock
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1);
        checkOne("held_ini_en0", {13'b0, en0}, 16'h7);

        // Reset mid-sequence, then restart while ini stays high
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
        checkOne("midrst_before", {13'b0, en0}, 16'h1);
        applyStimulus(1'b1, 1'b1);
        checkOne("midrst_en0", {13'b0, en0}, 16'h0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1);
        checkOne("midrst_restart", {13'b0, en0}, 16'h7);

        // ini dropped after E+5
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
`ifdef SECUENCIADOR_ARRANQUE_ABORT_EN
        checkOne("abort_en0", {13'b0, en0}, 16'h0);
        checkOne("abort_ocupado", {15'b0, ocupado0}, 16'h0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        checkOne("abort_pre_e4", {13'b0, en0}, 16'h0);
        applyStimulus(1'b0, 1'b1);
        checkOne("abort_restart", {13'b0, en0}, 16'h1);
`else
        checkOne("noabort_ocupado", {15'b0, ocupado0}, 16'h1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);
        checkOne("noabort_en0", {13'b0, en0}, 16'h7);
        checkOne("noabort_listo", {15'b0, listo0}, 16'h1);
`endif

        // Random ini toggling with occasional resets
        i_rand = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r_rand = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) i_rand = ~i_rand;
            applyStimulus(r_rand, i_rand);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
